// File: rtl/rambyte_dp_if.sv
`default_nettype none
// ============================================================================
// Module      : rambyte_dp_if
// Description : Write/read port bundle for the rambyte_dp dual-port RAM.
// Revision    : 1.0  initial release
// ============================================================================
interface rambyte_dp_if #(
    parameter int DW = 16,
    parameter int AW = 8,
    parameter int BW = 8
);
    localparam int c_NL = DW / BW;

    logic              busy;
    logic              wr_ce;
    logic [c_NL-1:0]   wr_we;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_din;
    logic              rd_ce;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_dout;
    logic              rd_valid;

    modport master (
        input  busy,
        output wr_ce,
        output wr_we,
        output wr_addr,
        output wr_din,
        output rd_ce,
        output rd_addr,
        input  rd_dout,
        input  rd_valid
    );

    modport slave (
        output busy,
        input  wr_ce,
        input  wr_we,
        input  wr_addr,
        input  wr_din,
        input  rd_ce,
        input  rd_addr,
        output rd_dout,
        output rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/rambyte_dp.sv
`default_nettype none
// ============================================================================
// Module      : rambyte_dp
// Description : Simple dual-port RAM with per-lane write mask, selectable
//               collision semantics, optional output register and clear.
// Revision    : 1.0  initial release
// ============================================================================
module rambyte_dp #(
    parameter int DW     = 16,
    parameter int AW     = 8,
    parameter int BW     = 8,
    parameter int REGOUT = 0,
    parameter int WMODE  = 0,
    parameter int CLEAR  = 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    rambyte_dp_if.slave    bus
);

    localparam int            c_NL       = DW / BW;
    localparam int            c_DEPTH    = 2 ** AW;
    localparam logic [AW-1:0] c_ADDR_MAX = {AW{1'b1}};
    localparam logic [AW-1:0] c_ADDR_ONE = AW'(1);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_clr_cnt;
    logic [AW-1:0]     w_clr_cnt_nxt;
    logic              w_clr_we;
    logic              r_busy;

    logic [DW-1:0]     r_mem [c_DEPTH];

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_collide;
    logic [DW-1:0]     w_rd_old;
    logic [DW-1:0]     w_merge;
    logic [DW-1:0]     w_rd_data;

    logic [DW-1:0]     r_rd_data;
    logic              r_rd_valid;

    // ------------------------------------------------------------------
    // Sequencer: RESET -> (CLEAR) -> RUN.  The first clear write happens
    // on the very first edge after reset release, from the RESET state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_RESET;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_busy    <= (w_state_nxt != S_RUN);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_we      = 1'b0;
        case (r_state)
            S_RESET, S_CLEAR: begin
                if (CLEAR != 0) begin
                    w_clr_we      = 1'b1;
                    w_clr_cnt_nxt = r_clr_cnt + c_ADDR_ONE;
                    w_state_nxt   = (r_clr_cnt == c_ADDR_MAX) ? S_RUN : S_CLEAR;
                end else begin
                    w_state_nxt   = S_RUN;
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt   = S_RESET;
                w_clr_cnt_nxt = '0;
            end
        endcase
        if (rst) begin
            w_clr_we = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Request acceptance and storage
    // ------------------------------------------------------------------
    assign w_wr_acc = !rst && !r_busy && bus.wr_ce;
    assign w_rd_acc = !rst && !r_busy && bus.rd_ce;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_acc) begin
            for (int i = 0; i < c_NL; i++) begin
                if (bus.wr_we[i]) begin
                    r_mem[bus.wr_addr][i*BW +: BW] <= bus.wr_din[i*BW +: BW];
                end
            end
        end
    end

    // Merged word is what the array will hold after this edge's write.
    assign w_rd_old  = r_mem[bus.rd_addr];
    assign w_collide = w_wr_acc && w_rd_acc && (bus.wr_addr == bus.rd_addr);

    always_comb begin
        w_merge = w_rd_old;
        for (int i = 0; i < c_NL; i++) begin
            if (bus.wr_we[i]) begin
                w_merge[i*BW +: BW] = bus.wr_din[i*BW +: BW];
            end
        end
    end

    assign w_rd_data = ((WMODE != 0) && w_collide) ? w_merge : w_rd_old;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= w_rd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional output stage
    // ------------------------------------------------------------------
    generate
        if (REGOUT != 0) begin : g_regout
            logic [DW-1:0] r_out_data;
            logic          r_out_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_data  <= '0;
                    r_out_valid <= 1'b0;
                end else begin
                    r_out_valid <= r_rd_valid;
                    if (r_rd_valid) begin
                        r_out_data <= r_rd_data;
                    end
                end
            end

            assign bus.rd_dout  = r_out_data;
            assign bus.rd_valid = r_out_valid;
        end else begin : g_direct
            assign bus.rd_dout  = r_rd_data;
            assign bus.rd_valid = r_rd_valid;
        end
    endgenerate

    assign bus.busy = r_busy;

endmodule
`default_nettype wire

// File: doc/rambyte_dp.md
Name: rambyte_dp

Overview:
Simple dual-port synchronous RAM with a per-lane write mask. It is the successor to the single-port byte-masked RAM, with separate read and write ports, a configurable mask-lane width and an optional output pipeline stage. It adds selectable read/write collision semantics and an optional hardware clear sequencer that zeroes the array after reset. It sits in the memory family as the generic buffer/scratchpad macro model.

Parameters:
- DW, 16, data width in bits; must be a multiple of BW.
- AW, 8, address width; depth = 2**AW.
- BW, 8, mask-lane width in bits; number of lanes NL = DW/BW.
- REGOUT, 0, 1 adds an output register stage, making read latency 2.
- WMODE, 0, collision mode: 0 = read-first (old data), 1 = write-first (merged new data).
- CLEAR, 1, 1 zeroes the whole array after reset via an internal sequencer.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- busy  output  1  high while in reset or while clearing; port requests are ignored while high.
- wr_ce  input  1  write port enable.
- wr_we  input  NL  per-lane write mask; lane i covers bits [i*BW +: BW].
- wr_addr  input  AW  write address.
- wr_din  input  DW  write data.
- rd_ce  input  1  read port enable.
- rd_addr  input  AW  read address.
- rd_dout  output  DW  read data.
- rd_valid  output  1  one-cycle pulse aligned with new rd_dout data.

Behaviour:
- Reset (rst=1 at a rising edge):
  - busy=1, rd_valid=0, rd_dout=0, clear counter=0.
  - The output pipeline is flushed.
  - The array is not touched during rst.
- State machine states: RESET, CLEAR, RUN.
  - RESET: entered whenever rst=1, from any state. This includes reset mid-clear, where the counter restarts at 0.
  - CLEAR (only when CLEAR=1): starts on the first edge with rst=0.
    - On the k-th such edge, writes all-zero to address k-1.
    - After address 2**AW-1 is written, moves to RUN.
    - busy is registered and falls exactly 2**AW edges after rst release.
  - RUN: busy=0. With CLEAR=0, RESET goes straight to RUN and busy falls on the first edge with rst=0.
- Request gating:
  - A request is taken at an edge where busy=0 (sampled before the edge) and the enable is 1.
  - While busy=1, wr_ce and rd_ce are ignored: no write, no rd_valid.
- Write:
  - For each lane i with wr_we[i]=1, the lane is updated with wr_din.
  - Lanes with wr_we[i]=0 keep their value.
  - wr_ce=1 with wr_we=0 is a no-op.
- Read (REGOUT=0):
  - On the edge that accepts rd_ce, rd_dout gets mem[rd_addr] and rd_valid=1 for that cycle.
  - Latency is 1 edge.
- Read (REGOUT=1):
  - Data and valid pass through one extra register.
  - Latency is 2 edges, with full throughput of one read per cycle.
- Without an accepted read, rd_valid=0 and rd_dout holds its last value.
- Collision: read and write accepted on the same edge at the same address.
  - WMODE=0: the read returns pre-write contents.
  - WMODE=1: the read returns the merged word (wr_din in lanes where wr_we=1, old data elsewhere).
  - Different addresses never interact.
- Address wrap: not applicable. Addresses are full-range AW bits, with no out-of-range handling.
- Area: no reset of the array contents other than the CLEAR sequence.

Test Plan:
- Clear sweep (AW=4, CLEAR=1):
  - Preload garbage with CLEAR=0 semantics disabled, then pulse rst for 2 cycles.
  - Required: busy is high exactly 16 edges after rst release.
  - Required: reads of addresses 0..15 all return 0, with rd_valid 1 cycle after each rd_ce.
- Lane mask (DW=32, BW=8):
  - Write 0xAABBCCDD, mask 0xF to address 5; then write 0x11223344, mask 0x5.
  - Required: read of address 5 returns 0xAA22CC44.
- Collision:
  - Address 3 holds 0x1234. Same edge: write 0xABCD, mask 0x2 (DW=16, BW=8), plus read of address 3.
  - Required: WMODE=0 returns 0x1234 and WMODE=1 returns 0xAB34.
  - Required: a follow-up read returns 0xAB34 in both modes.
- Latency and throughput (REGOUT=1):
  - Issue back-to-back reads of addresses 0,1,2 holding 0x10,0x11,0x12.
  - Required: rd_valid is high on edges 2,3,4 with data 0x10,0x11,0x12 in order.
  - Required: rd_dout holds 0x12 afterwards with rd_valid=0.
- Reset mid-clear (AW=4):
  - Assert rst at clear address 7.
  - Required: busy stays high, the counter restarts, and busy falls 16 edges after the second release.
  - Required: requests issued while busy produce no write and no rd_valid.
- Gating:
  - Set wr_ce=1 with wr_we=0, and rd_ce=0.
  - Required: the array is unchanged and rd_valid stays 0.
